// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster mode constants and a helper for per-axis total count.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle: sync levels, data enable, coordinates, event pulses, frame count.
interface vga_timing_gen_if #(
  parameter int X_W     = 10,
  parameter int Y_W     = 10,
  parameter int FRAME_W = 8
);
  logic               hs;
  logic               vs;
  logic               de;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic               line_start;
  logic               frame_start;
  logic               animate;
  logic [FRAME_W-1:0] frame;

  modport master (output hs, vs, de, x, y, line_start, frame_start, animate, frame);
  modport slave  (input  hs, vs, de, x, y, line_start, frame_start, animate, frame);
endinterface

// File: rtl/vga_axis_cnt.sv
// One raster axis: wrapping position counter with decodes taken from the next position,
// so the parent can register them and land on the same cycle as the counter itself.
module vga_axis_cnt
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int W      = 10
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap,
  output logic         o_active,
  output logic         o_sync
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  logic [W-1:0] cnt_q, cnt_d;

  assign o_wrap = (cnt_q == W'(TOTAL - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (i_en) cnt_d = o_wrap ? '0 : cnt_q + W'(1);
  end

  // Reset parks on the last position so the first enable lands on 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= W'(TOTAL - 1);
    else       cnt_q <= cnt_d;
  end

  assign o_cnt    = cnt_d;
  assign o_active = (cnt_d < W'(ACTIVE));
  assign o_sync   = (cnt_d >= W'(ACTIVE + FP)) && (cnt_d < W'(ACTIVE + FP + SYNC));

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: all outputs registered, one cycle after the
// pixel strobe, describing the same raster position.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int X_W      = 10,
  parameter int Y_W      = 10,
  parameter int FRAME_W  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pix_stb,
  vga_timing_gen_if.master vga_o
);

  logic [X_W-1:0] h_cnt;
  logic [Y_W-1:0] v_cnt;
  logic h_wrap, h_act, h_sync;
  logic v_wrap, v_act, v_sync;
  logic v_en;

  assign v_en = i_pix_stb & h_wrap;

  vga_axis_cnt #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(X_W)) u_h_cnt (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_pix_stb),
    .o_cnt(h_cnt), .o_wrap(h_wrap), .o_active(h_act), .o_sync(h_sync)
  );

  vga_axis_cnt #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(Y_W)) u_v_cnt (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(v_en),
    .o_cnt(v_cnt), .o_wrap(v_wrap), .o_active(v_act), .o_sync(v_sync)
  );

  logic               hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic               animate_q, animate_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

  // Pulses qualify on the strobe; levels follow the counter's next position and so hold without it.
  always_comb begin
    de_d          = h_act & v_act;
    x_d           = de_d ? h_cnt : '0;
    y_d           = de_d ? v_cnt : '0;
    hs_d          = h_sync ? HS_POL : ~HS_POL;
    vs_d          = v_sync ? VS_POL : ~VS_POL;
    line_start_d  = i_pix_stb & h_wrap;
    frame_start_d = v_en & v_wrap;
    animate_d     = v_en && (v_cnt == Y_W'(V_ACTIVE));
    frame_d       = frame_start_d ? frame_q + FRAME_W'(1) : frame_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      animate_q     <= 1'b0;
      frame_q       <= '0;
    end else begin
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      animate_q     <= animate_d;
      frame_q       <= frame_d;
    end
  end

  assign vga_o.hs          = hs_q;
  assign vga_o.vs          = vs_q;
  assign vga_o.de          = de_q;
  assign vga_o.x           = x_q;
  assign vga_o.y           = y_q;
  assign vga_o.line_start  = line_start_q;
  assign vga_o.frame_start = frame_start_q;
  assign vga_o.animate     = animate_q;
  assign vga_o.frame       = frame_q;

endmodule
